// File: rtl/div_sequencer.sv
// div_sequencer: iterative radix-2 restoring divider with its own controller
// for the RV32M DIV/DIVU/REM/REMU group. It holds the pipeline through stall
// while iterating. It returns one result pulse with the destination register.
// Divide-by-zero and signed overflow resolve in one cycle without iterating.
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_start,
    input  logic [2:0]      div_op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            busy
);

    localparam int              CW       = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement negate when requested; used for |x| and the final sign fix.
    function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (ZERO - v) : v;
    endfunction

    state_t          state_r;
    state_t          state_next_s;
    logic [CW-1:0]   counter_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] divisor_r;
    logic [XLEN-1:0] result_r;
    logic [4:0]      rd_out_r;
    logic            is_rem_r;
    logic            q_neg_r;
    logic            r_neg_r;

    logic            start_s;
    logic            is_signed_s;
    logic            is_rem_s;
    logic            div_zero_s;
    logic            ovf_s;
    logic [XLEN-1:0] rs1_abs_s;
    logic [XLEN-1:0] rs2_abs_s;
    logic [XLEN:0]   rem_shift_s;
    logic [XLEN:0]   trial_s;
    logic [XLEN-1:0] rem_step_s;
    logic [XLEN-1:0] quo_step_s;

    // Request decode; a flush in the same cycle cancels the request outright.
    assign start_s     = (state_r == ST_IDLE) & div_start & div_op[2] & ~flush;
    assign is_signed_s = ~div_op[0];
    assign is_rem_s    = div_op[1];
    assign div_zero_s  = (rs2_val == ZERO);
    assign ovf_s       = is_signed_s & (rs1_val == MIN_NEG) & (rs2_val == ONES);
    assign rs1_abs_s   = cond_neg(is_signed_s & rs1_val[XLEN-1], rs1_val);
    assign rs2_abs_s   = cond_neg(is_signed_s & rs2_val[XLEN-1], rs2_val);

    // One restoring step: shift in the next dividend bit, keep the trial difference if non-negative.
    always_comb begin
        rem_shift_s = {rem_r, quo_r[XLEN-1]};
        trial_s     = rem_shift_s - {1'b0, divisor_r};
        rem_step_s  = rem_shift_s[XLEN-1:0];
        quo_step_s  = {quo_r[XLEN-2:0], 1'b0};
        if (!trial_s[XLEN]) begin
            rem_step_s = trial_s[XLEN-1:0];
            quo_step_s = {quo_r[XLEN-2:0], 1'b1};
        end else begin
            rem_step_s = rem_shift_s[XLEN-1:0];
            quo_step_s = {quo_r[XLEN-2:0], 1'b0};
        end
    end

    // Next-state logic; flush overrides every transition and returns to IDLE.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_next_s = (div_zero_s | ovf_s) ? ST_DONE : ST_RUN;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (counter_r == CNT_ZERO) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_DONE: state_next_s = ST_IDLE;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, iteration and sign-corrected result; a flushed op never updates the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter_r <= CNT_ZERO;
            rem_r     <= ZERO;
            quo_r     <= ZERO;
            divisor_r <= ZERO;
            result_r  <= ZERO;
            rd_out_r  <= 5'd0;
            is_rem_r  <= 1'b0;
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else if (start_s) begin
            rd_out_r  <= rd_in;
            is_rem_r  <= is_rem_s;
            q_neg_r   <= is_signed_s & (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
            r_neg_r   <= is_signed_s & rs1_val[XLEN-1];
            divisor_r <= rs2_abs_s;
            quo_r     <= rs1_abs_s;
            rem_r     <= ZERO;
            counter_r <= CNT_LAST;
            if (div_zero_s) begin
                result_r <= is_rem_s ? rs1_val : ONES;
            end else if (ovf_s) begin
                result_r <= is_rem_s ? ZERO : rs1_val;
            end else begin
                result_r <= result_r;
            end
        end else if ((state_r == ST_RUN) && !flush) begin
            rem_r <= rem_step_s;
            quo_r <= quo_step_s;
            if (counter_r == CNT_ZERO) begin
                result_r <= is_rem_r ? cond_neg(r_neg_r, rem_step_s)
                                     : cond_neg(q_neg_r, quo_step_s);
            end else begin
                counter_r <= counter_r - {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stall        = start_s | (state_r == ST_RUN);
    assign result_valid = (state_r == ST_DONE) & ~flush;
    assign busy         = (state_r != ST_IDLE);
    assign result       = result_r;
    assign rd_out       = rd_out_r;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: expected results come from a behavioural
// RISC-V divide model and are popped when result_valid pulses.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        div_start;
    logic [2:0]  div_op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        busy;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic [31:0] due;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    div_sequencer #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .div_start    (div_start),
        .div_op       (div_op),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .rd_in        (rd_in),
        .flush        (flush),
        .stall        (stall),
        .result_valid (result_valid),
        .result       (result),
        .rd_out       (rd_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Cycle index; cycle k spans posedge k to posedge k+1.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'b100:  return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
            3'b101:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110:  return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
            3'b111:  return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Result monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (result_valid) begin
            if (sb.size() == 0) begin
                check_eq("spurious_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("result", result, e.res);
                check_eq("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
                check_eq("latency", 32'(cyc), e.due);
                check_eq("stall_in_done", {31'd0, stall}, 32'd0);
            end
        end
    end

    // Issues one op at posedge+1; returns at posedge+1 of the cycle after the result.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit hold);
        int   lat;
        int   stalls = 0;
        bit   done = 1'b0;
        exp_t e;
        lat   = is_special(op, a, b) ? 1 : 33;
        e.res = ref_div(op, a, b);
        e.rd  = rd;
        e.due = 32'(cyc + lat);
        sb.push_back(e);
        div_start = 1'b1;
        div_op    = op;
        rs1_val   = a;
        rs2_val   = b;
        rd_in     = rd;
        @(negedge clk);
        if (stall) stalls++;
        @(posedge clk); #1;
        if (!hold) div_start = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (stall) stalls++;
            #1;
            if (sb.size() == 0) done = 1'b1;
        end
        if (!done) begin
            check_eq("timeout", 32'd0, 32'd1);
            sb.delete();
        end
        check_eq("stall_cycles", 32'(stalls), 32'(lat));
        @(posedge clk); #1;
        div_start = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        div_start = 1'b0;
        div_op    = 3'b000;
        rs1_val   = 32'd0;
        rs2_val   = 32'd0;
        rd_in     = 5'd0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_rd", {27'd0, rd_out}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_valid", {31'd0, result_valid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases, issued back to back.
        run_op(3'b100, 32'd100, 32'd7, 5'd5, 1'b0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b0);
        run_op(3'b101, 32'hFFFF_FFFF, 32'd1, 5'd8, 1'b0);
        run_op(3'b100, 32'd77, 32'd0, 5'd9, 1'b0);
        run_op(3'b111, 32'h0000_1234, 32'd0, 5'd10, 1'b0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
        run_op(3'b111, 32'd5, 32'd9, 5'd13, 1'b0);
        run_op(3'b110, 32'd7, 32'hFFFF_FFFE, 5'd14, 1'b0);
        run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b0);
        // div_start held through DONE must not start a second op.
        run_op(3'b101, 32'd40, 32'd0, 5'd16, 1'b1);
        run_op(3'b100, 32'd1000, 32'd10, 5'd17, 1'b1);

        // Non-divide op code is not a request.
        div_start = 1'b1; div_op = 3'b001; rs1_val = 32'd8; rs2_val = 32'd2;
        @(negedge clk);
        check_eq("ignored_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        div_start = 1'b0;
        check_eq("ignored_busy", {31'd0, busy}, 32'd0);

        // Flush concurrent with a request cancels it.
        div_start = 1'b1; div_op = 3'b100; rs1_val = 32'd50; rs2_val = 32'd5; flush = 1'b1;
        @(negedge clk);
        check_eq("flush_req_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        div_start = 1'b0; flush = 1'b0;
        check_eq("flush_req_busy", {31'd0, busy}, 32'd0);

        // Flush at cycle 10 of a DIV, then an immediate DIVU 9/3.
        div_start = 1'b1; div_op = 3'b100; rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd20;
        repeat (10) begin
            @(posedge clk); #1;
            div_start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        check_eq("flush_run_busy", {31'd0, busy}, 32'd1);
        check_eq("flush_run_valid", {31'd0, result_valid}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("flush_run_idle", {31'd0, busy}, 32'd0);
        run_op(3'b101, 32'd9, 32'd3, 5'd21, 1'b0);

        // Flush landing on DONE masks the pulse.
        div_start = 1'b1; div_op = 3'b100; rs1_val = 32'd5; rs2_val = 32'd0; rd_in = 5'd22;
        @(posedge clk); #1;
        div_start = 1'b0; flush = 1'b1;
        @(negedge clk);
        check_eq("flush_done_busy", {31'd0, busy}, 32'd1);
        check_eq("flush_done_valid", {31'd0, result_valid}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("flush_done_idle", {31'd0, busy}, 32'd0);

        // Reset at cycle 5 of a REM clears everything silently.
        div_start = 1'b1; div_op = 3'b110; rs1_val = 32'hFFFF_FFF9; rs2_val = 32'd2; rd_in = 5'd23;
        repeat (5) begin
            @(posedge clk); #1;
            div_start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("mid_rst_result", result, 32'd0);
        check_eq("mid_rst_rd", {27'd0, rd_out}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_stall", {31'd0, stall}, 32'd0);
        repeat (40) @(posedge clk);
        #1;

        // Random back-to-back ops, occasionally with a zero divisor.
        for (int i = 0; i < 12; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = {1'b1, 2'($urandom_range(0, 3))};
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            run_op(op, a, b, 5'($urandom_range(0, 31)), 1'b0);
        end

        repeat (3) @(posedge clk);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
